reverser: RTL and testbench

REVERSER -- requirements
Module: reverser

---
 rtl/reverser_pkg.sv | 14 +
 rtl/reverser_if.sv | 10 +
 rtl/reverser_bcd_digit_complement.sv | 14 +
 rtl/reverser.sv | 69 ++++++
 tb/tb_reverser.sv | 134 +++++++++++++
 5 files changed

// File: rtl/reverser_pkg.sv
// Shared constants and types for the BCD reverser.
package reverser_pkg;

  typedef enum logic {
    MODE_A = 1'b0,
    MODE_B = 1'b1
  } mode_e;

  localparam logic [3:0] BCD_MAX_DIGIT   = 4'd9;
  localparam logic [3:0] MODE_B_MAX_TENS = 4'd5;
  localparam logic [3:0] MODE_B_MAX_ONES = 4'd9;
  localparam logic [7:0] ERR_OUT_VALUE   = 8'h00;

endpackage

// File: rtl/reverser_if.sv
// Data/flag bundle between the reverser and its driver.
interface reverser_if;
  logic [7:0] RevIn;
  logic       ModeSel;
  logic [7:0] RevOut;
  logic       Err;

  modport master (output RevIn, output ModeSel, input RevOut, input Err);
  modport slave  (input RevIn, input ModeSel, output RevOut, output Err);
endinterface

// File: rtl/reverser_bcd_digit_complement.sv
// Single BCD digit complement against a limit, with an out-of-range flag.
module bcd_digit_complement (
  input  logic [3:0] digit,
  input  logic [3:0] limit,
  output logic [3:0] diff,
  output logic       over
);

  always_comb begin
    over = (digit > limit);
    diff = limit - digit;
  end

endmodule

// File: rtl/reverser.sv
// Two-digit BCD pass-through (mode A) or 59-complement (mode B), one-cycle latency.
module reverser
  import reverser_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  reverser_if.slave   bus
);

  logic [3:0] tens_in, ones_in;
  logic [3:0] tens_cmp, ones_cmp;
  logic       tens_over_b, ones_over;
  logic       in_valid;
  mode_e      mode;

  logic [7:0] rev_out_d, rev_out_q;
  logic       err_d, err_q;

  assign tens_in = bus.RevIn[7:4];
  assign ones_in = bus.RevIn[3:0];
  assign mode    = mode_e'(bus.ModeSel);

  bcd_digit_complement u_tens (
    .digit (tens_in),
    .limit (MODE_B_MAX_TENS),
    .diff  (tens_cmp),
    .over  (tens_over_b)
  );

  bcd_digit_complement u_ones (
    .digit (ones_in),
    .limit (MODE_B_MAX_ONES),
    .diff  (ones_cmp),
    .over  (ones_over)
  );

  always_comb begin
    in_valid  = 1'b0;
    rev_out_d = ERR_OUT_VALUE;
    err_d     = 1'b1;
    case (mode)
      MODE_A: begin
        // Ones limit matches BCD_MAX_DIGIT, so the ones flag serves both modes.
        in_valid = (tens_in <= BCD_MAX_DIGIT) && !ones_over;
        if (in_valid) rev_out_d = {tens_in, ones_in};
      end
      MODE_B: begin
        in_valid = !tens_over_b && !ones_over;
        if (in_valid) rev_out_d = {tens_cmp, ones_cmp};
      end
      default: ;
    endcase
    if (in_valid) err_d = 1'b0;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rev_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      rev_out_q <= rev_out_d;
      err_q     <= err_d;
    end
  end

  assign bus.RevOut = rev_out_q;
  assign bus.Err    = err_q;

endmodule

// File: tb/tb_reverser.sv
// Directed self-checking bench for the BCD reverser.
module tb_reverser;

  logic Clk;
  logic Rst;
  int unsigned total;
  int unsigned bad;

  reverser_if bus ();

  reverser dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] exp_out, input logic exp_err);
    total++;
    assert (bus.RevOut === exp_out && bus.Err === exp_err)
    else begin
      bad++;
      $error("FAIL %s: observed out=%h err=%b expected out=%h err=%b",
             tag, bus.RevOut, bus.Err, exp_out, exp_err);
    end
  endtask

  // Drive on the falling edge, check 1 time unit after the following rising edge.
  task automatic step(input string tag, input logic [7:0] din, input logic mode,
                      input logic [7:0] exp_out, input logic exp_err);
    @(negedge Clk);
    bus.RevIn   = din;
    bus.ModeSel = mode;
    @(posedge Clk);
    #1;
    check(tag, exp_out, exp_err);
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] e;
    total = 0;
    bad   = 0;

    // Reset with arbitrary inputs
    Rst         = 1'b1;
    bus.RevIn   = 8'h37;
    bus.ModeSel = 1'b1;
    #1;
    check("reset_imm", 8'h00, 1'b0);
    @(posedge Clk); #1;
    check("reset_hold1", 8'h00, 1'b0);
    @(posedge Clk); #1;
    check("reset_hold2", 8'h00, 1'b0);

    // First edge after release gives a normal result
    @(negedge Clk);
    Rst         = 1'b0;
    bus.RevIn   = 8'h23;
    bus.ModeSel = 1'b1;
    #1;
    check("post_release_pre_edge", 8'h00, 1'b0);
    @(posedge Clk); #1;
    check("first_after_reset", 8'h36, 1'b0);

    // Mode B sweep 00..59
    for (int t = 0; t <= 5; t++) begin
      for (int o = 0; o <= 9; o++) begin
        v = {4'(t), 4'(o)};
        e = {4'(5 - t), 4'(9 - o)};
        step("modeB_sweep", v, 1'b1, e, 1'b0);
      end
    end

    // Mode A sweep 00..99
    for (int t = 0; t <= 9; t++) begin
      for (int o = 0; o <= 9; o++) begin
        v = {4'(t), 4'(o)};
        step("modeA_sweep", v, 1'b0, v, 1'b0);
      end
    end

    // Named boundaries
    step("modeB_00", 8'h00, 1'b1, 8'h59, 1'b0);
    step("modeB_59", 8'h59, 1'b1, 8'h00, 1'b0);
    step("modeA_99", 8'h99, 1'b0, 8'h99, 1'b0);
    step("modeA_00", 8'h00, 1'b0, 8'h00, 1'b0);
    step("modeA_47", 8'h47, 1'b0, 8'h47, 1'b0);

    // Invalid inputs and recovery
    step("modeB_60_inv",  8'h60, 1'b1, 8'h00, 1'b1);
    step("recover_1",     8'h23, 1'b1, 8'h36, 1'b0);
    step("modeB_3A_inv",  8'h3A, 1'b1, 8'h00, 1'b1);
    step("recover_2",     8'h41, 1'b0, 8'h41, 1'b0);
    step("modeA_A0_inv",  8'hA0, 1'b0, 8'h00, 1'b1);
    step("recover_3",     8'h05, 1'b1, 8'h54, 1'b0);
    step("modeA_9A_inv",  8'h9A, 1'b0, 8'h00, 1'b1);
    step("modeB_99_inv",  8'h99, 1'b1, 8'h00, 1'b1);
    step("modeA_FF_inv",  8'hFF, 1'b0, 8'h00, 1'b1);
    step("recover_4",     8'h90, 1'b0, 8'h90, 1'b0);

    // Mode switch with held input
    step("switch_A_12", 8'h12, 1'b0, 8'h12, 1'b0);
    step("switch_B_12", 8'h12, 1'b1, 8'h47, 1'b0);
    step("switch_A_back", 8'h12, 1'b0, 8'h12, 1'b0);

    // Async reset mid-cycle while output is 59
    step("pre_async_59", 8'h00, 1'b1, 8'h59, 1'b0);
    #2;
    Rst = 1'b1;
    #1;
    check("async_clear", 8'h00, 1'b0);
    @(negedge Clk);
    Rst         = 1'b0;
    bus.RevIn   = 8'h58;
    bus.ModeSel = 1'b1;
    @(posedge Clk); #1;
    check("after_async_release", 8'h01, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
